// File: rtl/inner_prod_pkg.sv
// Shared definitions for the sequential inner-product block: default sizes,
// result-width helper and FSM state encoding.
package inner_prod_pkg;

    localparam int ELEM_W_DEF = 8;
    localparam int N_ELEM_DEF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two guard bits cover the sum of up to four full-scale products.
    function automatic int res_width(input int elem_w);
        return 2 * elem_w + 2;
    endfunction

endpackage

// File: rtl/LR_Wallace_8x8.sv
// Unsigned 8x8 multiplier: partial products reduced by layers of 3:2
// carry-save adders, then one carry-propagate add.
module LR_Wallace_8x8 (
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic [15:0] prod
);

    logic [15:0] pp [8];
    logic [15:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

    // Returns {carry, sum}; the carry word is pre-shifted into its column.
    function automatic logic [31:0] csa(input logic [15:0] u, input logic [15:0] v,
                                        input logic [15:0] w);
        logic [15:0] s;
        logic [15:0] c;
        s = u ^ v ^ w;
        c = ((u & v) | (u & w) | (v & w)) << 1;
        return {c, s};
    endfunction

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            pp[i] = y[i] ? ({8'b0, x} << i) : 16'b0;
        end
    end

    assign {c0, s0} = csa(pp[0], pp[1], pp[2]);
    assign {c1, s1} = csa(pp[3], pp[4], pp[5]);
    assign {c2, s2} = csa(s0, c0, s1);
    assign {c3, s3} = csa(c1, pp[6], pp[7]);
    assign {c4, s4} = csa(s2, c2, s3);
    assign {c5, s5} = csa(s4, c4, c3);
    assign prod     = s5 + c5;

endmodule

// File: rtl/inner_prod_seq.sv
// Sequential unsigned inner product sum(a_i*b_i) over one shared multiplier.
// Build option INNER_PROD_SEQ_PIPE_EN registers the product before the adder.
module inner_prod_seq
    import inner_prod_pkg::*;
#(
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int N_ELEM = N_ELEM_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ELEM_W*N_ELEM-1:0] a,
    input  logic [ELEM_W*N_ELEM-1:0] b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*ELEM_W+1:0]      p,
    output logic                     busy
);

    localparam int ACC_W  = res_width(ELEM_W);
    localparam int PROD_W = 2 * ELEM_W;
    localparam int IDX_W  = $clog2(N_ELEM + 1);
`ifdef INNER_PROD_SEQ_PIPE_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);
`endif

    state_t                     state, state_nxt;
    logic [ELEM_W*N_ELEM-1:0]   a_q, b_q;
    logic [IDX_W-1:0]           idx;
    logic [ACC_W-1:0]           acc;
    logic [ELEM_W-1:0]          mul_x, mul_y;
    logic [PROD_W-1:0]          prod;
    logic                       accept;

    assign accept = in_valid && in_ready;
    assign busy   = (state != IDLE);
    assign p      = acc;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = MUL;
            end
            MUL:  if (idx == LAST_IDX) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    // Indices past the last element feed zeros into the multiplier.
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            if (idx == IDX_W'(i)) begin
                mul_x = a_q[i*ELEM_W +: ELEM_W];
                mul_y = b_q[i*ELEM_W +: ELEM_W];
            end
        end
    end

    LR_Wallace_8x8 u_mul (
        .x    (mul_x),
        .y    (mul_y),
        .prod (prod)
    );

`ifdef INNER_PROD_SEQ_PIPE_EN
    logic [PROD_W-1:0] prod_p1;
    logic              vld_p1;

    // Stage p1: registered product, accumulated one cycle after it is formed.
    always_ff @(posedge clk) begin
        prod_p1 <= prod;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            idx    <= '0;
            vld_p1 <= 1'b0;
        end else if (accept) begin
            acc    <= '0;
            idx    <= '0;
            vld_p1 <= 1'b0;
        end else if (state == MUL) begin
            if (vld_p1) acc <= acc + ACC_W'(prod_p1);
            vld_p1 <= (idx != LAST_IDX);
            if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            idx <= '0;
        end else if (accept) begin
            acc <= '0;
            idx <= '0;
        end else if (state == MUL) begin
            acc <= acc + ACC_W'(prod);
            if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_inner_prod_seq.sv
// Directed self-checking bench for inner_prod_seq (either build of
// INNER_PROD_SEQ_PIPE_EN).
module tb_inner_prod_seq;

`ifdef INNER_PROD_SEQ_PIPE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] a;
    logic [23:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] p;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inner_prod_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    task automatic send(input logic [23:0] va, input logic [23:0] vb, output bit ok);
        int n;
        ok = 1'b0;
        n = 0;
        a = va;
        b = vb;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (in_ready) begin
            @(posedge clk); #1;
            ok = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (p !== 18'd0) begin errors++; $display("FAIL reset_p: got %0d expected 0", p); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit ok;
        int n;
        send(24'h030201, 24'h060504, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_accept: got %b expected 1", ok); end
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy: got busy=%b in_ready=%b expected 1/0", busy, in_ready); end
        wait_valid(n);
        checks++; if (n != LAT) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", n, LAT); end
        checks++; if (p !== 18'd32) begin errors++; $display("FAIL basic_p: got %0d expected 32", p); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_done_in_ready: got %b expected 0", in_ready); end
        release_result();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_release_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_release_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_max();
        bit ok;
        int n;
        send(24'hFFFFFF, 24'hFFFFFF, ok);
        wait_valid(n);
        checks++; if (n != LAT) begin errors++; $display("FAIL max_latency: got %0d expected %0d", n, LAT); end
        checks++; if (p !== 18'd195075) begin errors++; $display("FAIL max_p: got %0d expected 195075", p); end
        release_result();
    endtask

    task automatic test_stall();
        bit ok;
        int n;
        send(24'h030201, 24'h060504, ok);
        wait_valid(n);
        in_valid = 1'b1;
        a = 24'h090909;
        b = 24'h090909;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (p !== 18'd32) begin errors++; $display("FAIL stall_p[%0d]: got %0d expected 32", i, p); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL stall_handoff: got busy=%b out_valid=%b expected 0/0", busy, out_valid); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_no_accept: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        int n;
        send(24'h030201, 24'h060504, ok);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (p !== 18'd0) begin errors++; $display("FAIL rstmid_p: got %0d expected 0", p); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", in_ready); end
        seen = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_stray_result: got %b expected 0", seen); end
        send(24'h000001, 24'h000007, ok);
        wait_valid(n);
        checks++; if (out_valid !== 1'b1 || p !== 18'd7) begin errors++; $display("FAIL rstmid_next_p: got valid=%b p=%0d expected 1/7", out_valid, p); end
        release_result();
    endtask

    task automatic test_back_to_back();
        int  acc_cyc [2];
        int  res [2];
        int  nacc, nres, cyc;
        bit  take_acc, take_res;
        logic [17:0] res_val;
        nacc = 0;
        nres = 0;
        cyc = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        res[0] = 0; res[1] = 0;
        a = 24'h030201;
        b = 24'h060504;
        in_valid = 1'b1;
        out_ready = 1'b1;
        while (nres < 2 && cyc < 60) begin
            take_acc = in_valid && in_ready;
            take_res = out_valid && out_ready;
            res_val = p;
            @(posedge clk); #1;
            cyc++;
            if (take_acc && nacc < 2) begin
                acc_cyc[nacc] = cyc;
                nacc++;
                if (nacc == 1) begin
                    a = 24'hFFFFFF;
                    b = 24'hFFFFFF;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (take_res && nres < 2) begin
                res[nres] = int'(res_val);
                nres++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++; if (nres != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", nres); end
        checks++; if (res[0] != 32) begin errors++; $display("FAIL b2b_first: got %0d expected 32", res[0]); end
        checks++; if (res[1] != 195075) begin errors++; $display("FAIL b2b_second: got %0d expected 195075", res[1]); end
        checks++; if (acc_cyc[1] - acc_cyc[0] != LAT + 2) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", acc_cyc[1] - acc_cyc[0], LAT + 2); end
        @(posedge clk); #1;
    endtask

    task automatic test_change();
        int n;
        a = 24'h010101;
        b = 24'h020202;
        in_valid = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL change_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            a = 24'($urandom);
            b = 24'($urandom);
            @(posedge clk); #1;
            n++;
        end
        checks++; if (n != LAT) begin errors++; $display("FAIL change_latency: got %0d expected %0d", n, LAT); end
        checks++; if (p !== 18'd6) begin errors++; $display("FAIL change_p: got %0d expected 6", p); end
        release_result();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inner_prod_seq.md
INNER_PROD_SEQ -- requirements
Module: inner_prod_seq

Interface
REQ-001 SHALL have parameter ELEM_W, default 8, meaning vector element width in bits.
REQ-002 SHALL have parameter N_ELEM, default 3, meaning elements per vector.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning operand vectors a/b present.
REQ-006 SHALL have port in_ready, output, 1, meaning block accepts operands this cycle.
REQ-007 SHALL have port a, input, ELEM_W*N_ELEM (24), meaning packed vector, element i at bits [8i+7:8i].
REQ-008 SHALL have port b, input, ELEM_W*N_ELEM (24), meaning packed vector, same packing as a.
REQ-009 SHALL have port out_valid, output, 1, meaning result p is valid.
REQ-010 SHALL have port out_ready, input, 1, meaning consumer takes p.
REQ-011 SHALL have port p, output, 2*ELEM_W+2 (18), meaning unsigned inner product sum(a_i*b_i).
REQ-012 SHALL have port busy, output, 1, meaning state is not IDLE.

Function
REQ-013 SHALL time-share one 8x8 unsigned multiplier across all N_ELEM element pairs; exactly one product per cycle.
REQ-014 SHALL implement states IDLE, MUL, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 SHALL in IDLE, on in_valid&in_ready, latch a and b, clear accumulator, clear index, go to MUL.
REQ-016 SHALL in MUL, each cycle, add product of element index to accumulator and increment index; after index N_ELEM-1, go to DONE.
REQ-017 SHALL process elements in index order 0 to N_ELEM-1 and ignore a/b changes after the accept edge.
REQ-018 SHALL, in the default build, assert out_valid N_ELEM cycles (3) after the accept edge.
REQ-019 SHALL hold p and out_valid stable in DONE until out_ready is high; on that edge go to IDLE.
REQ-020 SHALL not accept new operands in the DONE-to-IDLE handoff cycle; the earliest re-accept is the cycle after out_valid drops.
REQ-021 SHALL size the accumulator to 18 bits so the maximum result (3*255*255 = 195075) never wraps.
REQ-022 SHALL drive p from the accumulator register only (no combinational path from a/b to p).

Reset
REQ-023 SHALL on rst_n low at a clock edge force IDLE, accumulator 0, index 0, p 0, out_valid 0, busy 0, in_ready 1 on the next cycle.
REQ-024 SHALL abort any in-flight MUL or DONE on reset with no result delivered; a pending handshake in the reset cycle is dropped.

Configuration
REQ-025 SHALL support macro INNER_PROD_SEQ_PIPE_EN.
REQ-026 SHALL, with INNER_PROD_SEQ_PIPE_EN defined, register the multiplier output before the adder: MUL lasts N_ELEM+1 cycles and out_valid rises N_ELEM+1 cycles (4) after accept.
REQ-027 SHALL, without the macro, add the product combinationally in the same cycle, with latency per REQ-018.
REQ-028 SHALL give identical p values and handshake semantics in both builds; only latency differs.

Structure
REQ-029 SHALL place ELEM_W/N_ELEM defaults, result width, and state encodings (IDLE=0, MUL=1, DONE=2) in shared package inner_prod_pkg.
REQ-030 SHALL instantiate the existing LR_Wallace_8x8 multiplier as its single sub-module; no other multipliers.

Verification
REQ-031 SHALL cover: a=0x030201, b=0x060504 accepted, out_ready=1 -> out_valid after 3 cycles (4 with PIPE_EN), p=32.
REQ-032 SHALL cover: a=b=0xFFFFFF -> p=195075 (0x2FA03), no wrap.
REQ-033 SHALL cover: out_ready held low 5 cycles in DONE -> p and out_valid stable, in_ready=0; in_valid during this time is not accepted.
REQ-034 SHALL cover: rst_n low for one cycle while in MUL index 1 -> next cycle IDLE, p=0, no out_valid; a following transaction a=0x000001, b=0x000007 gives p=7.
REQ-035 SHALL cover: back-to-back transactions with in_valid held high and out_ready=1 -> results 32 then 195075 in order; accepts spaced per REQ-020.
REQ-036 SHALL cover: a/b changed every cycle after accept of a=0x010101, b=0x020202 -> p=6.
